// File: rtl/xor_accum_ctrl_pkg.sv
// Shared widths, limits and state encoding for the XOR accumulator controller.
// The term-count legality check lives here so any controller variant applies the same rule.
package xor_accum_ctrl_pkg;

  localparam int XAC_WIDTH     = 136;
  localparam int XAC_MAX_TERMS = 16;
  localparam int CNT_W         = 5;

  typedef logic [1:0] xac_state_t;

  localparam xac_state_t ST_IDLE = 2'd0;
  localparam xac_state_t ST_ACC  = 2'd1;
  localparam xac_state_t ST_OUT  = 2'd2;

  function automatic logic terms_legal(input logic [CNT_W-1:0] n,
                                       input logic [CNT_W-1:0] max_n);
    return (n != '0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/xor_accum_ctrl_if.sv
// Job, term and result handshake bundle between a term producer/consumer and the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface xor_accum_ctrl_if
  import xor_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = XAC_WIDTH
);

  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             term_valid;
  logic [WIDTH-1:0] term_data;
  logic             term_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             cfg_err;

  modport master (
    output start, num_terms, term_valid, term_data, out_ready,
    input  term_ready, out_valid, out_data, busy, cfg_err
  );

  modport slave (
    input  start, num_terms, term_valid, term_data, out_ready,
    output term_ready, out_valid, out_data, busy, cfg_err
  );

endinterface

// File: rtl/xor_accum_ctrl_xor.sv
// Carry-free GF(2) addition of two WIDTH-bit operands.
module xor_136 #(
  parameter int WIDTH = 136
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);

  assign C = A ^ B;

endmodule

// File: rtl/xor_accum_ctrl.sv
// Folds a job of num_terms GF(2^m) partial products into one XOR sum and hands it downstream.
//
// state | meaning
// IDLE  | no job; start/num_terms sampled here
// ACC   | accepting terms until the last one of the job is taken
// OUT   | result presented until downstream accepts it
module xor_accum_ctrl
  import xor_accum_ctrl_pkg::*;
#(
  parameter int WIDTH     = XAC_WIDTH,
  parameter int MAX_TERMS = XAC_MAX_TERMS
) (
  input logic             clk,
  input logic             rst,
  xor_accum_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  xac_state_t       state;
  xac_state_t       state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             cfg_err_q;
  logic             job_ok;
  logic             job_load;
  logic             job_bad;
  logic             term_hs;
  logic             last_term;

  assign job_ok    = terms_legal(bus.num_terms, MAX_CNT);
  assign job_load  = (state == ST_IDLE) && bus.start && job_ok;
  assign job_bad   = (state == ST_IDLE) && bus.start && !job_ok;
  assign term_hs   = (state == ST_ACC) && bus.term_valid;
  assign last_term = term_hs && (cnt == CNT_W'(1));

  xor_136 #(
    .WIDTH (WIDTH)
  ) u_xor (
    .A (acc),
    .B (bus.term_data),
    .C (acc_sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (job_load)      state_nxt = ST_ACC;
      ST_ACC:  if (last_term)     state_nxt = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_err_q <= job_bad;
      if (job_load) begin
        acc <= '0;
        cnt <= bus.num_terms;
      end else if (term_hs) begin
        acc <= acc_sum;
        // floor at zero so a stray handshake can never wrap the count
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.term_ready = (state == ST_ACC);
  assign bus.out_valid  = (state == ST_OUT);
  assign bus.out_data   = (state == ST_OUT) ? acc : '0;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_xor_accum_ctrl.sv
// Table-driven bench for xor_accum_ctrl with a result scoreboard and a few hand-built corner sequences.
module tb_xor_accum_ctrl;
  import xor_accum_ctrl_pkg::*;

  localparam int W = XAC_WIDTH;

  typedef struct {
    logic [4:0]   n;
    bit           shift;
    logic [W-1:0] t0;
    logic [W-1:0] t1;
    logic [W-1:0] t2;
    int           bubbles;
    int           stall;
    bit           poke;
    bit           exp_err;
    logic [W-1:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  xor_accum_ctrl_if #(.WIDTH(W)) bus();

  xor_accum_ctrl #(
    .WIDTH     (W),
    .MAX_TERMS (XAC_MAX_TERMS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           checks = 0;
  int           errors = 0;
  int           hs_count = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] n, input bit shift, input logic [W-1:0] t0,
                              input logic [W-1:0] t1, input logic [W-1:0] t2, input int bubbles,
                              input int stall, input bit poke, input bit exp_err,
                              input logic [W-1:0] exp_data);
    vec_t v;
    v.n = n; v.shift = shift; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.bubbles = bubbles; v.stall = stall; v.poke = poke;
    v.exp_err = exp_err; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic logic [W-1:0] term_of(input vec_t v, input int i);
    if (v.shift) return v.t0 << i;
    if (i % 3 == 0) return v.t0;
    if (i % 3 == 1) return v.t1;
    return v.t2;
  endfunction

  // Output monitor: scoreboard pops, idle-zero and stall-stability checks, handshake counting.
  initial begin
    logic         hold_q;
    logic [W-1:0] hold_data;
    hold_q = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_q = 1'b0;
      end else begin
        if (bus.term_valid && bus.term_ready) hs_count++;
        if (hold_q) begin
          check1("valid_stable", bus.out_valid, 1'b1);
          checkw("data_stable", bus.out_data, hold_data);
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: out_valid=1 data=%0h with no result pending at %0t",
                     bus.out_data, $time);
          end else if (bus.out_ready) begin
            checkw("out_data", bus.out_data, exp_q.pop_front());
          end
        end else begin
          checkw("out_data_zero_when_invalid", bus.out_data, '0);
        end
        hold_q = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
      end
    end
  end

  task automatic run_job(input vec_t v);
    int hs0;
    bus.start = 1'b1;
    bus.num_terms = v.n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (v.exp_err) begin
      check1("cfg_err_pulse", bus.cfg_err, 1'b1);
      check1("err_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
      check1("cfg_err_one_cycle", bus.cfg_err, 1'b0);
      check1("err_busy_after", bus.busy, 1'b0);
      return;
    end
    check1("cfg_err_quiet", bus.cfg_err, 1'b0);
    check1("busy_in_acc", bus.busy, 1'b1);
    check1("term_ready_in_acc", bus.term_ready, 1'b1);
    exp_q.push_back(v.exp_data);
    hs0 = hs_count;
    for (int i = 0; i < int'(v.n); i++) begin
      for (int b = 0; b < v.bubbles; b++) begin
        bus.term_valid = 1'b0;
        bus.term_data = {W{1'b1}};
        if (v.poke) begin
          bus.start = 1'b1;
          bus.num_terms = 5'd1;
        end
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.term_valid = 1'b1;
      bus.term_data = term_of(v, i);
      @(posedge clk); #1;
    end
    bus.term_valid = 1'b0;
    bus.term_data = '0;
    check1("out_valid_latency", bus.out_valid, 1'b1);
    check1("term_ready_low_in_out", bus.term_ready, 1'b0);
    for (int s = 0; s < v.stall; s++) begin
      bus.out_ready = 1'b0;
      if (v.poke) begin
        bus.start = 1'b1;
        bus.num_terms = 5'd1;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkw("handshake_count", W'(hs_count - hs0), W'(v.n));
    check1("out_valid_drop", bus.out_valid, 1'b0);
    check1("busy_drop", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(mk(5'd1,  0, 136'hA5, '0, '0, 0, 0, 0, 0, 136'hA5));
    vecs.push_back(mk(5'd3,  0, 136'hF0, 136'h0F, 136'hFF, 2, 0, 0, 0, '0));
    vecs.push_back(mk(5'd16, 0, {W{1'b1}}, {W{1'b1}}, {W{1'b1}}, 0, 5, 0, 0, '0));
    vecs.push_back(mk(5'd0,  0, '0, '0, '0, 0, 0, 0, 1, '0));
    vecs.push_back(mk(5'd17, 0, '0, '0, '0, 0, 0, 0, 1, '0));
    vecs.push_back(mk(5'd31, 0, '0, '0, '0, 0, 0, 0, 1, '0));
    vecs.push_back(mk(5'd2,  1, 136'h1, '0, '0, 1, 1, 0, 0, 136'h3));
    vecs.push_back(mk(5'd4,  1, 136'h3, '0, '0, 0, 2, 0, 0, 136'h11));
    vecs.push_back(mk(5'd16, 1, {W{1'b1}}, '0, '0, 0, 0, 0, 0, 136'h5555));
    vecs.push_back(mk(5'd2,  1, {1'b1, {(W-1){1'b0}}}, '0, '0, 1, 0, 0, 0, {1'b1, {(W-1){1'b0}}}));
    vecs.push_back(mk(5'd3,  0, 136'h1234, 136'hFF00, 136'h0F0F, 1, 3, 1, 0, 136'hE23B));
    vecs.push_back(mk(5'd15, 1, 136'h1, '0, '0, 0, 0, 0, 0, 136'h7FFF));

    // reset wins over a simultaneous start, term and out_ready
    rst = 1'b1;
    bus.start = 1'b1;
    bus.num_terms = 5'd1;
    bus.term_valid = 1'b1;
    bus.term_data = {W{1'b1}};
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_term_ready", bus.term_ready, 1'b0);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    checkw("rst_out_data", bus.out_data, '0);
    check1("rst_cfg_err", bus.cfg_err, 1'b0);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.term_valid = 1'b0;
    bus.term_data = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check1("idle_after_rst", bus.busy, 1'b0);

    foreach (vecs[k]) run_job(vecs[k]);

    // abort a 4-term job after two terms; reset coincides with a third term
    bus.start = 1'b1;
    bus.num_terms = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.term_valid = 1'b1;
      bus.term_data = W'(8'h40) << i;
      @(posedge clk); #1;
    end
    bus.term_data = 136'h80;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.term_valid = 1'b0;
    bus.term_data = '0;
    check1("abort_busy", bus.busy, 1'b0);
    check1("abort_term_ready", bus.term_ready, 1'b0);
    check1("abort_out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check1("no_stale_out_valid", bus.out_valid, 1'b0);
    end
    bus.out_ready = 1'b0;
    run_job(mk(5'd1, 0, 136'h3, '0, '0, 0, 0, 0, 0, 136'h3));

    repeat (2) @(posedge clk);
    #1;
    checkw("scoreboard_drained", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
